chip8_fb_draw_engine: RTL

//  Owns the 64x32 Chip-8 monochrome framebuffer and serves it to the VGA scan-out block.

---
 rtl/chip8_fb_draw_engine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/chip8_fb_draw_engine.sv
// chip8_fb_draw_engine
//   Owns the 64x32 monochrome Chip-8 framebuffer. The VGA scan-out reads one
//   pixel per cycle. The CPU core issues CLS (clear) and DRW (XOR sprite)
//   commands.
//
//   Ports
//     clk50, reset        system clock; asynchronous active-high reset
//     fb_request_addr     pixel address {row, col}
//     fb_pixel_data       registered pixel at fb_request_addr (1-cycle latency)
//     cmd_valid/ready     command handshake; cmd_op 0=CLS, 1=DRW
//     cmd_x/y/n           DRW start column, start row, sprite height
//     spr_valid/ready     sprite byte handshake; spr_data MSB = leftmost pixel
//     done                one-cycle pulse when a command completes
//     collision           DRW result, held until the next DRW accept
//
//   Build option: define CHIP8_FB_SPRITE_WRAP_EN to wrap sprites around the
//   screen edges. With it undefined, off-screen pixels are clipped.
module chip8_fb_draw_engine #(
  parameter int unsigned COL_BITS = 6,
  parameter int unsigned ROW_BITS = 5,
  parameter int unsigned SPR_W    = 8
) (
  input  logic                         clk50,
  input  logic                         reset,
  input  logic [ROW_BITS+COL_BITS-1:0] fb_request_addr,
  output logic                         fb_pixel_data,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_op,
  input  logic [COL_BITS-1:0]          cmd_x,
  input  logic [ROW_BITS-1:0]          cmd_y,
  input  logic [3:0]                   cmd_n,
  input  logic                         spr_valid,
  output logic                         spr_ready,
  input  logic [SPR_W-1:0]             spr_data,
  output logic                         done,
  output logic                         collision
);

  localparam int unsigned COLS = 1 << COL_BITS;
  localparam int unsigned ROWS = 1 << ROW_BITS;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW} state_e;

  state_e                state_q, state_d;
  logic [ROW_BITS-1:0]   row_ctr_q, row_ctr_d;
  logic [COL_BITS-1:0]   x_q, x_d;
  logic [ROW_BITS-1:0]   y_q, y_d;
  logic [3:0]            n_q, n_d;
  logic [3:0]            i_q, i_d;
  logic                  coll_q, coll_d;
  logic                  done_q, done_d;
  logic                  pix_q;

  logic [COLS-1:0]       fb_q [ROWS];

  // Row write port shared by CLEAR and DRAW.
  logic                  we;
  logic [ROW_BITS-1:0]   wsel;
  logic [COLS-1:0]       wdata;

  // Sprite placement for the current byte.
  logic [ROW_BITS:0]     row_sum;
  logic [ROW_BITS-1:0]   row_sel;
  logic                  row_ok;
  logic [COL_BITS:0]     col;
  logic [COLS-1:0]       mask;

  always_comb begin
    row_sum = {1'b0, y_q} + (ROW_BITS+1)'(i_q);
    row_sel = row_sum[ROW_BITS-1:0];
`ifdef CHIP8_FB_SPRITE_WRAP_EN
    row_ok  = 1'b1;
`else
    row_ok  = ~row_sum[ROW_BITS];
`endif
    mask = '0;
    col  = '0;
    for (int unsigned k = 0; k < SPR_W; k++) begin
      col = {1'b0, x_q} + (COL_BITS+1)'(k);
`ifdef CHIP8_FB_SPRITE_WRAP_EN
      if (spr_data[SPR_W-1-k]) mask[col[COL_BITS-1:0]] = 1'b1;
`else
      if (spr_data[SPR_W-1-k] && !col[COL_BITS]) mask[col[COL_BITS-1:0]] = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    row_ctr_d = row_ctr_q;
    x_d       = x_q;
    y_d       = y_q;
    n_d       = n_q;
    i_d       = i_q;
    coll_d    = coll_q;
    done_d    = 1'b0;
    we        = 1'b0;
    wsel      = row_ctr_q;
    wdata     = '0;
    cmd_ready = 1'b0;
    spr_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!cmd_op) begin
            state_d   = S_CLEAR;
            row_ctr_d = '0;
          end else begin
            x_d    = cmd_x;
            y_d    = cmd_y;
            n_d    = cmd_n;
            i_d    = '0;
            coll_d = 1'b0;
            if (cmd_n == 4'd0) done_d  = 1'b1;
            else               state_d = S_DRAW;
          end
        end
      end
      S_CLEAR: begin
        we        = 1'b1;
        wsel      = row_ctr_q;
        wdata     = '0;
        row_ctr_d = row_ctr_q + 1'b1;
        if (row_ctr_q == ROW_BITS'(ROWS - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_DRAW: begin
        spr_ready = 1'b1;
        if (spr_valid) begin
          // Off-screen rows still consume the byte but leave pixels and collision alone.
          if (row_ok) begin
            we     = 1'b1;
            wsel   = row_sel;
            wdata  = fb_q[row_sel] ^ mask;
            coll_d = coll_q | (|(fb_q[row_sel] & mask));
          end
          i_d = i_q + 4'd1;
          if (i_q == n_q - 4'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_ctr_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      n_q       <= '0;
      i_q       <= '0;
      coll_q    <= 1'b0;
      done_q    <= 1'b0;
      pix_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_ctr_q <= row_ctr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      n_q       <= n_d;
      i_q       <= i_d;
      coll_q    <= coll_d;
      done_q    <= done_d;
      // Samples fb_q before this edge's row update, so reads see the old value.
      pix_q     <= fb_q[fb_request_addr[ROW_BITS+COL_BITS-1:COL_BITS]][fb_request_addr[COL_BITS-1:0]];
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < ROWS; r++) fb_q[r] <= '0;
    end else if (we) begin
      fb_q[wsel] <= wdata;
    end
  end

  assign fb_pixel_data = pix_q;
  assign done          = done_q;
  assign collision     = coll_q;

endmodule
